// File: rtl/apuf_pkg.sv
// Shared types and default sizing for the arbiter-PUF response path.
package apuf_pkg;
  localparam int APUF_CHAL_W     = 64;
  localparam int APUF_NUM_EVAL   = 15;
  localparam int APUF_SETTLE_CYC = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRECHARGE = 2'd1,
    FIRE      = 2'd2,
    DONE      = 2'd3
  } apuf_state_e;
endpackage

// File: rtl/apuf_sync2.sv
// Two-flop synchronizer for single-bit asynchronous signals; resets to 0.
module apuf_sync2 (
  input  logic iclk,
  input  logic irst_n,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) sync_q <= '0;
    else         sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];
endmodule

// File: rtl/apuf_resp_reader.sv
// Arbiter-PUF response reader: drives the challenge, fires repeated races and
// majority-votes the synchronized arbiter samples into one response bit.
module apuf_resp_reader
  import apuf_pkg::*;
#(
  parameter int CHAL_W     = APUF_CHAL_W,
  parameter int NUM_EVAL   = APUF_NUM_EVAL,
  parameter int SETTLE_CYC = APUF_SETTLE_CYC,
  localparam int CW        = $clog2(NUM_EVAL+1)
) (
  input  logic              iclk,
  input  logic              irst_n,
  input  logic              ichal_valid,
  input  logic [CHAL_W-1:0] ichal,
  output logic              ochal_ready,
  output logic [CHAL_W-1:0] ochal,
  output logic              olaunch,
  input  logic              iarb,
  output logic              oresp_valid,
  output logic              oresp,
  output logic [CW-1:0]     oones_count,
  input  logic              iresp_ready,
  output logic              obusy
);
  localparam int TW = $clog2(SETTLE_CYC+3);
  localparam logic [TW-1:0] PRE_LAST  = TW'(SETTLE_CYC-1);
  localparam logic [TW-1:0] FIRE_LAST = TW'(SETTLE_CYC+1);
  localparam logic [CW-1:0] EVAL_LAST = CW'(NUM_EVAL-1);
  localparam logic [CW-1:0] HALF      = CW'(NUM_EVAL/2);

  apuf_state_e       state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [CW-1:0]     eval_q, eval_d;
  logic [CW-1:0]     ones_q, ones_d;
  logic [CHAL_W-1:0] chal_q, chal_d;
  logic              launch_q, launch_d;
  logic              rvld_q, rvld_d;
  logic              resp_q, resp_d;
  logic [CW-1:0]     ones_out_q, ones_out_d;
  logic              arb_sync;

  apuf_sync2 u_arb_sync (
    .iclk   (iclk),
    .irst_n (irst_n),
    .d_i    (iarb),
    .q_o    (arb_sync)
  );

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      eval_q     <= '0;
      ones_q     <= '0;
      chal_q     <= '0;
      launch_q   <= 1'b0;
      rvld_q     <= 1'b0;
      resp_q     <= 1'b0;
      ones_out_q <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      eval_q     <= eval_d;
      ones_q     <= ones_d;
      chal_q     <= chal_d;
      launch_q   <= launch_d;
      rvld_q     <= rvld_d;
      resp_q     <= resp_d;
      ones_out_q <= ones_out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    eval_d     = eval_q;
    ones_d     = ones_q;
    chal_d     = chal_q;
    rvld_d     = rvld_q;
    resp_d     = resp_q;
    ones_out_d = ones_out_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (ichal_valid) begin
          chal_d  = ichal;
          eval_d  = '0;
          ones_d  = '0;
          state_d = PRECHARGE;
        end
      end
      PRECHARGE: begin
        if (timer_q == PRE_LAST) begin
          timer_d = '0;
          state_d = FIRE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      FIRE: begin
        // Last launch cycle: the sync output now reflects this race's arbiter.
        if (timer_q == FIRE_LAST) begin
          timer_d = '0;
          ones_d  = ones_q + CW'(arb_sync);
          eval_d  = eval_q + CW'(1);
          state_d = (eval_q == EVAL_LAST) ? DONE : PRECHARGE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DONE: begin
        // First DONE cycle loads the result registers; they hold until taken.
        if (!rvld_q) begin
          rvld_d     = 1'b1;
          resp_d     = (ones_q > HALF);
          ones_out_d = ones_q;
        end else if (iresp_ready) begin
          rvld_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    launch_d = (state_d == FIRE);
  end

  assign ochal_ready = (state_q == IDLE);
  assign obusy       = (state_q != IDLE);
  assign ochal       = chal_q;
  assign olaunch     = launch_q;
  assign oresp_valid = rvld_q;
  assign oresp       = resp_q;
  assign oones_count = ones_out_q;
endmodule

// File: tb/tb_apuf_resp_reader.sv
// Directed/randomized bench for apuf_resp_reader with NUM_EVAL=3, SETTLE_CYC=2.
module tb_apuf_resp_reader;
  localparam int CHAL_W = 64;
  localparam int NE     = 3;
  localparam int SC     = 2;
  localparam int CW     = $clog2(NE+1);
  localparam int EV_CYC = 2*SC + 2;
  localparam int LAT    = NE*EV_CYC + 1;

  logic              iclk = 1'b0;
  logic              irst_n;
  logic              ichal_valid;
  logic [CHAL_W-1:0] ichal;
  logic              ochal_ready;
  logic [CHAL_W-1:0] ochal;
  logic              olaunch;
  logic              iarb;
  logic              oresp_valid;
  logic              oresp;
  logic [CW-1:0]     oones_count;
  logic              iresp_ready;
  logic              obusy;

  int npass = 0;
  int ntot  = 0;
  int nfail = 0;

  apuf_resp_reader #(.CHAL_W(CHAL_W), .NUM_EVAL(NE), .SETTLE_CYC(SC)) dut (
    .iclk        (iclk),
    .irst_n      (irst_n),
    .ichal_valid (ichal_valid),
    .ichal       (ichal),
    .ochal_ready (ochal_ready),
    .ochal       (ochal),
    .olaunch     (olaunch),
    .iarb        (iarb),
    .oresp_valid (oresp_valid),
    .oresp       (oresp),
    .oones_count (oones_count),
    .iresp_ready (iresp_ready),
    .obusy       (obusy)
  );

  always #5 iclk = ~iclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  // Offer a challenge from IDLE, drive one arbiter value per evaluation and
  // check launch pattern, latency and voted result. Leaves the DUT in DONE.
  task automatic run_chal(input logic [CHAL_W-1:0] c, input logic [NE-1:0] bits,
                          input string tag);
    int lat;
    int ones;
    lat  = 0;
    ones = $countones(bits);
    chk({tag, "_ready"}, ochal_ready, 1'b1);
    ichal       = c;
    ichal_valid = 1'b1;
    tick();
    ichal_valid = 1'b0;
    ichal       = {$urandom, $urandom};
    iarb        = bits[0];
    chk({tag, "_ochal"}, ochal, c);
    chk({tag, "_busy"}, obusy, 1'b1);
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (oresp_valid) begin
        lat = k;
        break;
      end
      if (k < NE*EV_CYC) begin
        chk({tag, "_launch"}, olaunch, ((k % EV_CYC) >= SC));
        if ((k % EV_CYC) == 0) iarb = bits[k/EV_CYC];
      end
    end
    chk({tag, "_latency"}, lat, LAT);
    chk({tag, "_ones"}, oones_count, ones);
    chk({tag, "_resp"}, oresp, (ones > NE/2));
  endtask

  task automatic handshake(input string tag);
    iresp_ready = 1'b1;
    tick();
    iresp_ready = 1'b0;
    chk({tag, "_hs_vld"}, oresp_valid, 1'b0);
    chk({tag, "_hs_ready"}, ochal_ready, 1'b1);
  endtask

  initial begin
    logic [CHAL_W-1:0] c1, c2;
    logic [CW-1:0]     held_ones;
    logic              held_resp;
    logic [NE-1:0]     rb;
    int                seen;
    int                lat;

    // 1. reset with random inputs
    irst_n      = 1'b0;
    ichal_valid = $urandom_range(0, 1);
    ichal       = {$urandom, $urandom};
    iarb        = $urandom_range(0, 1);
    iresp_ready = $urandom_range(0, 1);
    #12;
    chk("rst_ready", ochal_ready, 1'b1);
    chk("rst_busy", obusy, 1'b0);
    chk("rst_ochal", ochal, 64'h0);
    chk("rst_launch", olaunch, 1'b0);
    chk("rst_vld", oresp_valid, 1'b0);
    chk("rst_resp", oresp, 1'b0);
    chk("rst_ones", oones_count, 0);
    ichal_valid = 1'b0;
    iresp_ready = 1'b0;
    iarb        = 1'b0;
    @(negedge iclk);
    irst_n = 1'b1;
    tick();

    // 2. all ones
    run_chal(64'hA5A5_A5A5_A5A5_A5A5, 3'b111, "all1");
    handshake("all1");
    chk("all1_keep_resp", oresp, 1'b1);
    chk("all1_keep_ones", oones_count, 3);

    // 3. minority ones (1,0,0 over the three windows)
    run_chal({$urandom, $urandom}, 3'b001, "minor");
    held_ones = oones_count;
    held_resp = oresp;
    c1        = ochal;

    // 4. backpressure in DONE while a new challenge is offered
    for (int i = 0; i < 5; i++) begin
      ichal_valid = 1'b1;
      ichal       = {$urandom, $urandom};
      tick();
      chk("bp_vld", oresp_valid, 1'b1);
      chk("bp_ones", oones_count, held_ones);
      chk("bp_resp", oresp, held_resp);
      chk("bp_ochal", ochal, c1);
      chk("bp_ready", ochal_ready, 1'b0);
    end
    ichal_valid = 1'b0;
    handshake("bp");
    chk("bp_idle_ochal", ochal, c1);
    chk("bp_idle_ones", oones_count, 1);

    // 5. reset during the second FIRE window
    ichal       = {$urandom, $urandom};
    ichal_valid = 1'b1;
    tick();
    ichal_valid = 1'b0;
    iarb        = 1'b1;
    for (int k = 1; k <= EV_CYC + SC + 1; k++) tick();
    chk("mid_launch_pre", olaunch, 1'b1);
    irst_n = 1'b0;
    #1;
    chk("mid_launch", olaunch, 1'b0);
    chk("mid_ochal", ochal, 64'h0);
    chk("mid_ready", ochal_ready, 1'b1);
    tick();
    tick();
    @(negedge iclk);
    irst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (oresp_valid) seen++;
    end
    chk("mid_no_resp", seen, 0);
    iarb = 1'b0;
    run_chal({$urandom, $urandom}, 3'b010, "post_rst");
    handshake("post_rst");

    // random challenges against the voting model
    for (int r = 0; r < 4; r++) begin
      rb = NE'($urandom);
      run_chal({$urandom, $urandom}, rb, "rand");
      handshake("rand");
    end

    // 6. back-to-back with iresp_ready tied high
    c1 = {$urandom, $urandom};
    c2 = {$urandom, $urandom};
    iarb        = 1'b1;
    iresp_ready = 1'b1;
    ichal       = c1;
    ichal_valid = 1'b1;
    tick();
    ichal = c2;
    lat   = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (oresp_valid) begin
        lat = k;
        break;
      end
    end
    chk("b2b_lat1", lat, LAT);
    tick();
    chk("b2b_hs_ochal", ochal, c1);
    chk("b2b_hs_ready", ochal_ready, 1'b1);
    tick();
    chk("b2b_acc_ochal", ochal, c2);
    chk("b2b_acc_busy", obusy, 1'b1);
    ichal_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (oresp_valid) begin
        lat = k;
        break;
      end
    end
    chk("b2b_lat2", lat, LAT);
    chk("b2b_ones2", oones_count, 3);
    tick();
    chk("b2b_idle", ochal_ready, 1'b1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
